// File: rtl/score_pkg.sv
// Shared types, widths and the saturating-add helper for the score tracker.
package score_pkg;

  localparam int SCORE_W       = 14;
  localparam int COMBO_W       = 3;
  localparam int CALC_W        = 16;
  localparam int MAX_SCORE_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Sum is formed at CALC_W so the ceiling test happens before any truncation.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] base,
    input logic [CALC_W-1:0]  inc,
    input logic [CALC_W-1:0]  ceiling
  );
    logic [CALC_W-1:0] sum;
    sum = {{(CALC_W-SCORE_W){1'b0}}, base} + inc;
    if (sum > ceiling) begin
      return SCORE_W'(ceiling);
    end else begin
      return SCORE_W'(sum);
    end
  endfunction

  function automatic logic [COMBO_W-1:0] combo_step(
    input logic [COMBO_W-1:0] cur,
    input logic [COMBO_W-1:0] cap
  );
    if (cur >= cap) begin
      return cap;
    end else begin
      return cur + COMBO_W'(1);
    end
  endfunction

endpackage

// File: rtl/combo_timer.sv
// Reloadable down-counter; alive stays high until the combo window has elapsed.
module combo_timer
  import score_pkg::*;
#(
  parameter int  COMBO_WINDOW = 50_000_000,
  localparam int TW           = $clog2(COMBO_WINDOW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          alive
);

  logic [TW-1:0] count_r;

  // Load has priority over the free-running decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign alive = (count_r != {TW{1'b0}});

endmodule

// File: rtl/score_tracker.sv
// Scorekeeper: game FSM, combo-multiplied saturating score and session high score.
module score_tracker
  import score_pkg::*;
#(
  parameter int MAX_SCORE    = MAX_SCORE_DEF,
  parameter int EGG_POINTS   = 1,
  parameter int BONUS_POINTS = 10,
  parameter int COMBO_MAX    = 4,
  parameter int COMBO_WINDOW = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               egg_caught,
  input  logic               bonus_caught,
  output logic [SCORE_W-1:0] score,
  output logic               new_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic [COMBO_W-1:0] combo,
  output logic               playing
);

  localparam int                 TW        = $clog2(COMBO_WINDOW + 1);
  localparam logic [COMBO_W-1:0] COMBO_CAP = COMBO_W'(COMBO_MAX);
  localparam logic [COMBO_W-1:0] COMBO_ONE = COMBO_W'(1);
  localparam logic [CALC_W-1:0]  CEIL      = CALC_W'(MAX_SCORE);
  localparam logic [CALC_W-1:0]  EGG_PTS   = CALC_W'(EGG_POINTS);
  localparam logic [CALC_W-1:0]  BONUS_PTS = CALC_W'(BONUS_POINTS);
  localparam logic [TW-1:0]      WINDOW    = TW'(COMBO_WINDOW);

  state_t              state_r;
  logic                catch_s;
  logic                alive_s;
  logic [COMBO_W-1:0]  combo_n_s;
  logic [CALC_W-1:0]   base_pts_s;
  logic [CALC_W-1:0]   points_s;
  logic [SCORE_W-1:0]  score_n_s;
  logic                load_s;
  logic [TW-1:0]       load_val_s;

  combo_timer #(
    .COMBO_WINDOW(COMBO_WINDOW)
  ) u_combo_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .load_val(load_val_s),
    .alive   (alive_s)
  );

  // Candidate score/combo for a catch this cycle; both catch kinds share one combo step.
  always_comb begin
    catch_s    = egg_caught | bonus_caught;
    combo_n_s  = COMBO_ONE;
    base_pts_s = {CALC_W{1'b0}};
    if (alive_s) begin
      combo_n_s = combo_step(combo, COMBO_CAP);
    end else begin
      combo_n_s = COMBO_ONE;
    end
    if (egg_caught) begin
      base_pts_s = base_pts_s + EGG_PTS;
    end else begin
      base_pts_s = base_pts_s;
    end
    if (bonus_caught) begin
      base_pts_s = base_pts_s + BONUS_PTS;
    end else begin
      base_pts_s = base_pts_s;
    end
    points_s  = base_pts_s * {{(CALC_W-COMBO_W){1'b0}}, combo_n_s};
    score_n_s = sat_add(score, points_s, CEIL);
  end

  // Timer reloads on an accepted catch and is cleared on game start and game over.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = {TW{1'b0}};
    case (state_r)
      IDLE, OVER: begin
        if (game_start) begin
          load_s     = 1'b1;
          load_val_s = {TW{1'b0}};
        end else begin
          load_s     = 1'b0;
          load_val_s = {TW{1'b0}};
        end
      end
      PLAY: begin
        if (game_over) begin
          load_s     = 1'b1;
          load_val_s = {TW{1'b0}};
        end else if (catch_s) begin
          load_s     = 1'b1;
          load_val_s = WINDOW;
        end else begin
          load_s     = 1'b0;
          load_val_s = {TW{1'b0}};
        end
      end
      default: begin
        load_s     = 1'b1;
        load_val_s = {TW{1'b0}};
      end
    endcase
  end

  // Game FSM with all outputs registered so score and new_score always move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      score      <= {SCORE_W{1'b0}};
      new_score  <= 1'b0;
      high_score <= {SCORE_W{1'b0}};
      new_high   <= 1'b0;
      combo      <= COMBO_ONE;
      playing    <= 1'b0;
    end else begin
      new_score <= 1'b0;
      new_high  <= 1'b0;
      case (state_r)
        IDLE, OVER: begin
          if (game_start) begin
            state_r   <= PLAY;
            score     <= {SCORE_W{1'b0}};
            new_score <= 1'b1;
            combo     <= COMBO_ONE;
            playing   <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        PLAY: begin
          // game_over wins over a same-cycle catch, which is dropped.
          if (game_over) begin
            state_r <= OVER;
            playing <= 1'b0;
            combo   <= COMBO_ONE;
            if (score > high_score) begin
              high_score <= score;
              new_high   <= 1'b1;
            end else begin
              high_score <= high_score;
            end
          end else if (catch_s) begin
            combo     <= combo_n_s;
            score     <= score_n_s;
            new_score <= (score_n_s != score);
          end else if (!alive_s) begin
            combo <= COMBO_ONE;
          end else begin
            combo <= combo;
          end
        end
        default: begin
          state_r <= IDLE;
          playing <= 1'b0;
          combo   <= COMBO_ONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed-vector bench for score_tracker with a short combo window.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        game_over;
  logic        egg_caught;
  logic        bonus_caught;
  logic [13:0] score;
  logic        new_score;
  logic [13:0] high_score;
  logic        new_high;
  logic [2:0]  combo;
  logic        playing;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  score_tracker #(
    .COMBO_WINDOW(8),
    .COMBO_MAX   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .game_start  (game_start),
    .game_over   (game_over),
    .egg_caught  (egg_caught),
    .bonus_caught(bonus_caught),
    .score       (score),
    .new_score   (new_score),
    .high_score  (high_score),
    .new_high    (new_high),
    .combo       (combo),
    .playing     (playing)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_score(input string tag, input int s, input int ns, input int c);
    check_val({tag, ".score"}, 32'(score), 32'(s));
    check_val({tag, ".new_score"}, 32'(new_score), 32'(ns));
    check_val({tag, ".combo"}, 32'(combo), 32'(c));
  endtask

  task automatic expect_game(input string tag, input int hs, input int nh, input int pl);
    check_val({tag, ".high_score"}, 32'(high_score), 32'(hs));
    check_val({tag, ".new_high"}, 32'(new_high), 32'(nh));
    check_val({tag, ".playing"}, 32'(playing), 32'(pl));
  endtask

  // Called at a falling edge; inputs are sampled by the next rising edge.
  task automatic step(input logic e, input logic b, input logic s, input logic o);
    egg_caught   = e;
    bonus_caught = b;
    game_start   = s;
    game_over    = o;
    @(negedge clk);
    egg_caught   = 1'b0;
    bonus_caught = 1'b0;
    game_start   = 1'b0;
    game_over    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ramp_score [5] = '{1, 3, 6, 10, 14};
  int ramp_combo [5] = '{1, 2, 3, 4, 4};

  initial begin
    reset        = 1'b1;
    game_start   = 1'b0;
    game_over    = 1'b0;
    egg_caught   = 1'b0;
    bonus_caught = 1'b0;
    idle(3);
    expect_score("reset", 0, 0, 1);
    expect_game("reset", 0, 0, 0);
    reset = 1'b0;

    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_score("idle_catch", 0, 0, 1);
    expect_game("idle_catch", 0, 0, 0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_score("start", 0, 1, 1);
    expect_game("start", 0, 0, 1);
    idle(1);
    check_val("start.pulse_end", 32'(new_score), 32'd0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      expect_score($sformatf("ramp%0d", i), ramp_score[i], 1, ramp_combo[i]);
      if (i < 4) idle(2);
    end
    idle(10);
    check_val("ramp.expired_combo", 32'(combo), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("ramp.after_expire", 15, 1, 1);

    idle(10);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_score("simul", 26, 1, 1);
    idle(1);
    check_val("simul.pulse_end", 32'(new_score), 32'd0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_score("start_in_play", 26, 0, 1);
    expect_game("start_in_play", 0, 0, 1);

    idle(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_score("b2b0", 36, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("b2b1", 38, 1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("b2b2", 41, 1, 3);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("to42", 42, 1, 1);

    step(1'b1, 1'b0, 1'b0, 1'b1);
    expect_score("over42", 42, 0, 1);
    expect_game("over42", 42, 1, 0);
    idle(1);
    check_val("over42.new_high_end", 32'(new_high), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_score("over_catch", 42, 0, 1);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_score("restart", 0, 1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_score("to30", 30, 1, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_score("over30", 30, 0, 1);
    expect_game("over30", 42, 0, 0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 251; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_score("preload", 9980, 1, 4);
    idle(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_score("pre9990", 9990, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("pre9992", 9992, 1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("pre9995", 9995, 1, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_score("sat", 9999, 1, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("sat_hold", 9999, 0, 4);

    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_score("midreset", 0, 0, 1);
    expect_game("midreset", 0, 0, 0);
    reset = 1'b0;

    step(1'b0, 1'b0, 1'b1, 1'b1);
    expect_score("both_idle", 0, 1, 1);
    expect_game("both_idle", 0, 0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    expect_score("both_play", 0, 0, 1);
    expect_game("both_play", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
